id_ex_skid_pipe_reg: RTL
========================

Name: id_ex_skid_pipe_reg

Overview:
- Parametrised ID->EX pipeline register with a valid/ready handshake and a 2-entry skid buffer. Backpressure from EX no longer drops or duplicates an instruction.
- Carries a generic payload bus (operands, pc, immediates, shift operand, dst, EXE_CMD) and a separate control-enable bus (S, B, MEM_W_EN, MEM_R_EN, WB_EN).
- Control enables are guaranteed zero whenever no valid instruction is presented (bubble).
- Adds a synchronous flush and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 136, payload width (pc, val_Rn, val_Rm, imm24, shift_operand, dst, EXE_CMD, imm flag packed by the instantiator)
CTRL_W, 5, control-enable width; these bits are forced to 0 in bubbles
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage can accept; registered, no combinational path from out_ready
in_data  in  DATA_W  incoming payload
in_ctrl  in  CTRL_W  incoming control enables
out_valid  out  1  EX-side instruction valid
out_ready  in  1  EX accepts this cycle
out_data  out  DATA_W  registered payload to EX
out_ctrl  out  CTRL_W  registered control enables to EX
cnt_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (drives out_*), skid register, and valid bits main_v and skid_v. out_valid=main_v; in_ready=~skid_v.
- Accept event: in_valid & in_ready. Release event: out_valid & out_ready.
- States: EMPTY (main_v=0, skid_v=0), FULL (1,0), SKID (1,1). Main=0 with skid=1 is illegal and unreachable.
- EMPTY: accept -> main<=in, go FULL. Otherwise stay.
- FULL, accept & release -> main<=in, stay FULL (throughput 1/cycle).
- FULL, accept & no release -> skid<=in, go SKID.
- FULL, release & no accept -> go EMPTY.
- FULL, neither -> hold.
- SKID: in_ready=0, so no accept. Release -> main<=skid, go FULL. Otherwise hold.
- Latency: data accepted at edge N appears on out_* after edge N when the stage was EMPTY or releasing. Order is strictly FIFO.
- Bubble rule: whenever main_v=0, out_data and out_ctrl are all zeros. Entering EMPTY (drain, flush, reset) loads zeros. Skid contents are zeroed when skid_v clears.
- Flush (sync, highest priority): next state EMPTY; all data regs zero; any same-cycle accept is discarded; in_ready=1 in the following cycle. A release in the flush cycle still completes normally at EX.
- Reset (async, any time incl. mid-SKID): main_v=skid_v=0, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, stall_cnt=0.
- stall_cnt: +1 each cycle with out_valid & ~out_ready. Saturates at 2^CNT_W-1. cnt_clr has priority over increment. Flush does not affect the counter.
- Holding: out_* must not change while out_valid=1 and out_ready=0.

Test Plan:
- Reset mid-SKID: fill two entries with out_ready=0, assert rst asynchronously between edges -> out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0 immediately.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, in_data=1..8 -> out_data=1..8 one cycle later, no gaps, in_ready stays 1.
- Backpressure: send A=0x11, B=0x22 with out_ready=0 -> out_data=0x11 held, in_ready=0 after B; C=0x33 offered is not accepted; raise out_ready -> outputs 0x11, 0x22, 0x33 in order, none lost or duplicated.
- Flush in SKID with in_valid=1, in_ctrl=5'b11111 -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; the flushed instruction never appears.
- Bubble control: in_valid=0 with in_ctrl=5'b10101 -> out_ctrl stays 0 on every cycle.
- Counter: out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. cnt_clr and stall in the same cycle -> 0. CNT_W=3 with 10 stall cycles -> saturates at 7.

Source files
------------

// File: rtl/id_ex_skid_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake and a two-entry skid buffer.
// Control enables read as zero in bubbles; includes sync flush and a saturating stall counter.
module id_ex_skid_pipe_reg #(
  parameter int DATA_W = 136,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] main_data_p1, main_data_n, skid_data_p1, skid_data_n;
  logic [CTRL_W-1:0] main_ctrl_p1, main_ctrl_n, skid_ctrl_p1, skid_ctrl_n;
  logic              accept, release_ev, stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Both handshake flags decode straight from the state flops, so in_ready never sees out_ready.
  assign out_valid  = (state != EMPTY);
  assign in_ready   = (state != SKID);
  assign accept     = in_valid & in_ready;
  assign release_ev = out_valid & out_ready;
  assign stall      = out_valid & ~out_ready;
  assign out_data   = main_data_p1;
  assign out_ctrl   = main_ctrl_p1;

  always_comb begin
    state_n     = state;
    main_data_n = main_data_p1;
    main_ctrl_n = main_ctrl_p1;
    skid_data_n = skid_data_p1;
    skid_ctrl_n = skid_ctrl_p1;
    if (flush) begin
      state_n     = EMPTY;
      main_data_n = '0;
      main_ctrl_n = '0;
      skid_data_n = '0;
      skid_ctrl_n = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data_n = in_data;
            main_ctrl_n = in_ctrl;
            state_n     = FULL;
          end
        end
        FULL: begin
          if (accept && release_ev) begin
            main_data_n = in_data;
            main_ctrl_n = in_ctrl;
          end else if (accept) begin
            skid_data_n = in_data;
            skid_ctrl_n = in_ctrl;
            state_n     = SKID;
          end else if (release_ev) begin
            // Draining to a bubble: clear so EX never sees stale enables.
            main_data_n = '0;
            main_ctrl_n = '0;
            state_n     = EMPTY;
          end
        end
        SKID: begin
          if (release_ev) begin
            main_data_n = skid_data_p1;
            main_ctrl_n = skid_ctrl_p1;
            skid_data_n = '0;
            skid_ctrl_n = '0;
            state_n     = FULL;
          end
        end
        default: begin
          state_n     = EMPTY;
          main_data_n = '0;
          main_ctrl_n = '0;
          skid_data_n = '0;
          skid_ctrl_n = '0;
        end
      endcase
    end
  end

  // Stage p1: state, main and skid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      main_data_p1 <= '0;
      main_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
    end else begin
      state        <= state_n;
      main_data_p1 <= main_data_n;
      main_ctrl_p1 <= main_ctrl_n;
      skid_data_p1 <= skid_data_n;
      skid_ctrl_p1 <= skid_ctrl_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
